// File: rtl/spi_response_scheduler.sv
// Frames pending digit/cost/status read-backs as tag+payload byte pairs in fixed
// priority and shifts them MSB-first onto MISO; streams IDLE_BYTE otherwise.
module spi_response_scheduler #(
  parameter logic [7:0] IDLE_BYTE  = 8'hFF,
  parameter logic [7:0] TAG_DIGIT  = 8'hA1,
  parameter logic [7:0] TAG_COST   = 8'hA2,
  parameter logic [7:0] TAG_STATUS = 8'hA3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       shift_SPI,
  input  logic       SS,
  input  logic       digit_valid,
  input  logic [3:0] detected_digit,
  input  logic       cost_valid,
  input  logic [7:0] cost_output,
  input  logic       status_req,
  output logic       MISO,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TAG  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [1:0] G_DIGIT  = 2'd0;
  localparam logic [1:0] G_COST   = 2'd1;
  localparam logic [1:0] G_STATUS = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] pend_q, pend_d;
  logic       dirty_q, dirty_d;
  logic [1:0] grant_q, grant_d;
  logic [2:0] ovr_q, ovr_d;
  logic       done_q, done_d;
  logic [3:0] digit_q, digit_d;
  logic [7:0] cost_q, cost_d;
  logic [7:0] snap_q, snap_d;

  logic [2:0] cap;
  logic [2:0] ovr_set;
  logic [2:0] grant_mask;
  logic       cap_grant;
  logic       boundary;

  function automatic logic [2:0] slot_mask(input logic [1:0] g);
    case (g)
      G_DIGIT: slot_mask = 3'b001;
      G_COST:  slot_mask = 3'b010;
      default: slot_mask = 3'b100;
    endcase
  endfunction

  always_comb begin
    cap        = {status_req, cost_valid, digit_valid};
    ovr_set    = cap & pend_q;
    grant_mask = slot_mask(grant_q);
    cap_grant  = |(cap & grant_mask);
    boundary   = shift_SPI && (cnt_q == 3'd7);

    digit_d = digit_valid ? detected_digit : digit_q;
    cost_d  = cost_valid ? cost_output : cost_q;
    pend_d  = pend_q | cap;
    ovr_d   = ovr_q | ovr_set;
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dirty_d = dirty_q;
    grant_d = grant_q;
    snap_d  = snap_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (SS) begin
          cnt_d = 3'd0;
          sr_d  = IDLE_BYTE;
        end else if (shift_SPI) begin
          cnt_d = cnt_q + 3'd1;
          sr_d  = boundary ? IDLE_BYTE : {sr_q[6:0], 1'b1};
        end else if ((cnt_q == 3'd0) && (|pend_q)) begin
          // Snapshot uses the forwarded capture so a same-cycle update is not lost
          state_d = S_TAG;
          dirty_d = 1'b0;
          if (pend_q[0]) begin
            grant_d = G_DIGIT;
            sr_d    = TAG_DIGIT;
            snap_d  = {4'h0, digit_d};
          end else if (pend_q[1]) begin
            grant_d = G_COST;
            sr_d    = TAG_COST;
            snap_d  = cost_d;
          end else begin
            grant_d = G_STATUS;
            sr_d    = TAG_STATUS;
          end
        end
      end
      S_TAG, S_DATA: begin
        if (SS) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
          sr_d    = IDLE_BYTE;
        end else begin
          if (cap_grant) dirty_d = 1'b1;
          if (shift_SPI) begin
            cnt_d = cnt_q + 3'd1;
            sr_d  = {sr_q[6:0], 1'b1};
            if (boundary) begin
              if (state_q == S_TAG) begin
                state_d = S_DATA;
                sr_d    = (grant_q == G_STATUS) ? {1'b0, ovr_q, 1'b0, pend_q} : snap_q;
              end else begin
                // A capture during the frame keeps the slot pending for a resend
                state_d = S_IDLE;
                sr_d    = IDLE_BYTE;
                done_d  = 1'b1;
                if (!dirty_q && !cap_grant) pend_d = pend_d & ~grant_mask;
                if (grant_q == G_STATUS) ovr_d = ovr_set;
              end
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
        sr_d    = IDLE_BYTE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      sr_q    <= IDLE_BYTE;
      pend_q  <= 3'b000;
      dirty_q <= 1'b0;
      grant_q <= G_DIGIT;
      ovr_q   <= 3'b000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      pend_q  <= pend_d;
      dirty_q <= dirty_d;
      grant_q <= grant_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
    end
  end

  // Payload storage is only consumed once its pending bit is set
  always_ff @(posedge clk) begin
    digit_q <= digit_d;
    cost_q  <= cost_d;
    snap_q  <= snap_d;
  end

  assign MISO       = SS ? 1'bz : sr_q[7];
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_spi_response_scheduler.sv
// Bench for spi_response_scheduler: directed byte-stream vectors plus random
// traffic checked every cycle against a byte/bit-position reference model.
module tb_spi_response_scheduler;

  localparam logic [7:0] IDLE_B = 8'hFF;
  localparam logic [7:0] TAG_D  = 8'hA1;
  localparam logic [7:0] TAG_C  = 8'hA2;
  localparam logic [7:0] TAG_S  = 8'hA3;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       shift_spi;
  logic       ss;
  logic       digit_valid;
  logic [3:0] detected_digit;
  logic       cost_valid;
  logic [7:0] cost_output;
  logic       status_req;
  wire        miso;
  logic       busy;
  logic       frame_done;
  logic [2:0] overrun;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  spi_response_scheduler #(
    .IDLE_BYTE(IDLE_B), .TAG_DIGIT(TAG_D), .TAG_COST(TAG_C), .TAG_STATUS(TAG_S)
  ) dut (
    .clk(clk), .n_rst(n_rst), .shift_SPI(shift_spi), .SS(ss),
    .digit_valid(digit_valid), .detected_digit(detected_digit),
    .cost_valid(cost_valid), .cost_output(cost_output), .status_req(status_req),
    .MISO(miso), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: which frame (slot) is on the wire, which half, bit position
  int         m_frame;
  bit         m_half;
  int         m_bits;
  logic [7:0] m_byte;
  logic [7:0] m_snap;
  logic [2:0] m_pend;
  logic [2:0] m_ovr;
  bit         m_dirty;
  bit         m_done;
  logic [7:0] m_data [2];

  function automatic logic [7:0] tag_of(input int s);
    if (s == 0) return TAG_D;
    if (s == 1) return TAG_C;
    return TAG_S;
  endfunction

  task automatic model_reset();
    m_frame = -1; m_half = 0; m_bits = 0; m_byte = IDLE_B; m_snap = 8'h00;
    m_pend = 3'b000; m_ovr = 3'b000; m_dirty = 0; m_done = 0;
  endtask

  task automatic model_step();
    logic [2:0] caps, pold, oold, novr;
    bit status_done;
    caps = {status_req, cost_valid, digit_valid};
    pold = m_pend;
    oold = m_ovr;
    novr = caps & pold;
    if (digit_valid) m_data[0] = {4'h0, detected_digit};
    if (cost_valid)  m_data[1] = cost_output;
    m_done = 0;
    status_done = 0;
    m_pend = pold | caps;
    if (m_frame >= 0 && caps[m_frame]) m_dirty = 1;
    if (ss) begin
      m_frame = -1; m_bits = 0; m_byte = IDLE_B;
    end else if (shift_spi) begin
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        if (m_frame < 0) m_byte = IDLE_B;
        else if (!m_half) begin
          m_half = 1;
          m_byte = (m_frame == 2) ? {1'b0, oold, 1'b0, pold} : m_snap;
        end else begin
          m_done = 1;
          if (!m_dirty) m_pend[m_frame] = 1'b0;
          if (m_frame == 2) status_done = 1;
          m_frame = -1;
          m_byte = IDLE_B;
        end
      end
    end else if (m_frame < 0 && m_bits == 0 && pold != 3'b000) begin
      m_frame = pold[0] ? 0 : (pold[1] ? 1 : 2);
      m_half  = 0;
      m_dirty = 0;
      m_byte  = tag_of(m_frame);
      m_snap  = (m_frame == 2) ? 8'h00 : m_data[m_frame];
    end
    m_ovr = status_done ? novr : (oold | novr);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [7:0] b;
    @(posedge clk);
    model_step();
    #1;
    b = m_byte;
    if (!ss) chk("miso", {31'd0, miso}, {31'd0, b[3'(7 - m_bits)]});
    chk("busy", {31'd0, busy}, {31'd0, m_frame >= 0});
    chk("overrun", {29'd0, overrun}, {29'd0, m_ovr});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
    if (frame_done) done_cnt++;
  endtask

  task automatic clear_inputs();
    shift_spi = 0; digit_valid = 0; cost_valid = 0; status_req = 0;
    detected_digit = 4'h0; cost_output = 8'h00;
  endtask

  task automatic shift1(inout logic [7:0] b);
    b = {b[6:0], miso};
    shift_spi = 1; tick();
    shift_spi = 0; tick();
  endtask

  task automatic read_byte(output logic [7:0] b);
    b = 8'h00;
    for (int k = 0; k < 8; k++) shift1(b);
  endtask

  task automatic do_reset();
    clear_inputs();
    n_rst = 0;
    model_reset();
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {29'd0, overrun}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    if (!ss) chk("rst_miso", {31'd0, miso}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1;
  endtask

  typedef struct {
    string      name;
    logic       dv;
    logic [3:0] dg;
    logic       cv;
    logic [7:0] co;
    int         nb;
    logic [31:0] exp;
    int         dones;
  } vec_t;

  vec_t vt[3];

  initial begin
    logic [7:0]  b;
    logic [31:0] got;
    int d0;
    bit prev_shift;

    vt[0] = '{"idle", 1'b0, 4'h0, 1'b0, 8'h00, 2, 32'h0000FFFF, 0};
    vt[1] = '{"digit7", 1'b1, 4'h7, 1'b0, 8'h00, 3, 32'h00A107FF, 1};
    vt[2] = '{"digit_cost", 1'b1, 4'h3, 1'b1, 8'h5C, 4, 32'hA103A25C, 2};

    clear_inputs();
    ss = 0;
    n_rst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_overrun", {29'd0, overrun}, 32'd0);
    chk("init_frame_done", {31'd0, frame_done}, 32'd0);
    chk("init_miso", {31'd0, miso}, 32'd1);
    @(negedge clk);
    n_rst = 1;
    tick();

    for (int v = 0; v < 3; v++) begin
      d0 = done_cnt;
      digit_valid = vt[v].dv; detected_digit = vt[v].dg;
      cost_valid = vt[v].cv;  cost_output = vt[v].co;
      tick();
      clear_inputs();
      tick(); tick();
      got = 32'd0;
      for (int i = 0; i < vt[v].nb; i++) begin
        read_byte(b);
        got = {got[23:0], b};
      end
      chk({vt[v].name, "_bytes"}, got, vt[v].exp);
      chk({vt[v].name, "_dones"}, done_cnt - d0, vt[v].dones);
      chk({vt[v].name, "_overrun"}, {29'd0, overrun}, 32'd0);
      chk({vt[v].name, "_busy"}, {31'd0, busy}, 32'd0);
    end

    // Cost re-captured while its tag byte is on the wire
    cost_valid = 1; cost_output = 8'h10; tick();
    clear_inputs(); tick(); tick();
    got = 32'd0; b = 8'h00;
    for (int i = 0; i < 32; i++) begin
      if (i == 3) begin
        cost_valid = 1; cost_output = 8'h20; tick();
        clear_inputs();
        chk("ovr_cost_set", {29'd0, overrun}, 32'h2);
      end
      shift1(b);
      if (i % 8 == 7) got = {got[23:0], b};
    end
    chk("cost_resend_bytes", got, 32'hA210A220);
    chk("cost_resend_ovr", {29'd0, overrun}, 32'h2);

    // Status frame reports overrun and pending, then clears overrun
    status_req = 1; tick();
    clear_inputs(); tick(); tick();
    got = 32'd0;
    for (int i = 0; i < 2; i++) begin read_byte(b); got = {got[23:0], b}; end
    chk("status_bytes", got, 32'h0000A324);
    chk("status_ovr_clr", {29'd0, overrun}, 32'd0);

    // Abort mid-payload, then complete resend
    d0 = done_cnt;
    digit_valid = 1; detected_digit = 4'h9; tick();
    clear_inputs(); tick(); tick();
    b = 8'h00;
    for (int i = 0; i < 11; i++) shift1(b);
    ss = 1; tick(); tick(); tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    ss = 0; tick(); tick();
    got = 32'd0;
    for (int i = 0; i < 2; i++) begin read_byte(b); got = {got[23:0], b}; end
    chk("abort_resend_bytes", got, 32'h0000A109);
    chk("abort_resend_done", done_cnt - d0, 32'd1);

    // Random traffic against the model, including select drops and a reset
    prev_shift = 0;
    for (int i = 0; i < 6000; i++) begin
      shift_spi = prev_shift ? 1'b0 : ($urandom_range(0, 2) == 0);
      prev_shift = shift_spi;
      if ($urandom_range(0, 299) == 0) ss = ~ss;
      digit_valid = ($urandom_range(0, 59) == 0);
      detected_digit = 4'($urandom);
      cost_valid = ($urandom_range(0, 59) == 0);
      cost_output = 8'($urandom);
      status_req = ($urandom_range(0, 89) == 0);
      tick();
      if (i == 3000) begin
        do_reset();
        prev_shift = 0;
      end
    end
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
